// File: rtl/alu_ram_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_ram_sequencer_if
// Purpose : bundles the command, datapath and response signals of the
//           ALU/register-file sequencer.
// Modports:
//   master - the sequencer. It takes in the command fields, the ALU
//            result/flags and rsp_ready. It drives cmd_ready, the register
//            file and ALU controls, the response fields and busy.
//   slave  - the host and datapath side. Its directions are the mirror
//            image of master.
// ---------------------------------------------------------------------------
interface alu_ram_sequencer_if;
  // command channel
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [2:0] cmd_op;
  logic [3:0] cmd_src0;
  logic [3:0] cmd_src1;
  logic [3:0] cmd_dst;
  logic [7:0] cmd_imm;
  // register file / ALU controls
  logic [7:0] dp_data;
  logic       dp_write_enable;
  logic [3:0] dp_addr_write;
  logic [3:0] dp_addr0;
  logic [3:0] dp_addr1;
  logic [2:0] dp_select;
  logic [7:0] dp_result;
  logic       dp_zero_flag;
  logic       dp_carry_flag;
  // response channel
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_zero;
  logic       rsp_carry;
  logic       rsp_error;
  logic       busy;

  modport master (
    input  cmd_valid, cmd_load, cmd_op, cmd_src0, cmd_src1, cmd_dst, cmd_imm,
    input  dp_result, dp_zero_flag, dp_carry_flag, rsp_ready,
    output cmd_ready, dp_data, dp_write_enable, dp_addr_write, dp_addr0,
    output dp_addr1, dp_select, rsp_valid, rsp_result, rsp_zero, rsp_carry,
    output rsp_error, busy
  );

  modport slave (
    output cmd_valid, cmd_load, cmd_op, cmd_src0, cmd_src1, cmd_dst, cmd_imm,
    output dp_result, dp_zero_flag, dp_carry_flag, rsp_ready,
    input  cmd_ready, dp_data, dp_write_enable, dp_addr_write, dp_addr0,
    input  dp_addr1, dp_select, rsp_valid, rsp_result, rsp_zero, rsp_carry,
    input  rsp_error, busy
  );
endinterface

// File: rtl/alu_ram_sequencer.sv
// ---------------------------------------------------------------------------
// alu_ram_sequencer
// Purpose : accepts one command at a time. A command is either an immediate
//           load into the register file or an ALU operation on two registers
//           that is written back to a third register. The sequencer steps an
//           external register file and ALU through the command, then returns
//           a response.
// Ports   :
//   clock   - rising-edge clock
//   reset_n - synchronous active-low reset
//   bus     - alu_ram_sequencer_if.master. It carries:
//             - the cmd_* handshake and fields;
//             - the dp_* register file and ALU controls, plus the ALU result
//               and flags;
//             - the rsp_* handshake, result and flags;
//             - busy.
// ---------------------------------------------------------------------------
module alu_ram_sequencer (
  input  logic                 clock,
  input  logic                 reset_n,
  alu_ram_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READ  = 3'd2,
    EXEC  = 3'd3,
    WRITE = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t     state_reg, state_next;

  logic [7:0] data_reg;
  logic [3:0] addr_write_reg;
  logic [3:0] addr0_reg;
  logic [3:0] addr1_reg;
  logic [2:0] select_reg;
  logic [7:0] result_reg;
  logic       zero_reg;
  logic       carry_reg;
  logic       error_reg;

  logic       accept;
  logic       op_legal;

  assign accept   = (state_reg == IDLE) && bus.cmd_valid;
  assign op_legal = (bus.cmd_op <= 3'd4);

  // Next state plus the outputs decoded straight from the state.
  always_comb begin
    state_next          = state_reg;
    bus.cmd_ready       = 1'b0;
    bus.busy            = 1'b1;
    bus.dp_write_enable = 1'b0;
    bus.rsp_valid       = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.cmd_valid) begin
          if (bus.cmd_load)  state_next = LOAD;
          else if (op_legal) state_next = READ;
          else               state_next = RESP;
        end
      end
      LOAD: begin
        bus.dp_write_enable = 1'b1;
        state_next          = RESP;
      end
      READ:  state_next = EXEC;
      EXEC:  state_next = WRITE;
      WRITE: begin
        bus.dp_write_enable = 1'b1;
        state_next          = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      data_reg       <= 8'd0;
      addr_write_reg <= 4'd0;
      addr0_reg      <= 4'd0;
      addr1_reg      <= 4'd0;
      select_reg     <= 3'd0;
      result_reg     <= 8'd0;
      zero_reg       <= 1'b0;
      carry_reg      <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        if (bus.cmd_load) begin
          // The load response is known at accept time. The write data is
          // presented during LOAD.
          addr_write_reg <= bus.cmd_dst;
          data_reg       <= bus.cmd_imm;
          result_reg     <= bus.cmd_imm;
          zero_reg       <= (bus.cmd_imm == 8'd0);
          carry_reg      <= 1'b0;
          error_reg      <= 1'b0;
        end else if (op_legal) begin
          // The read addresses are loaded here so they are already valid in
          // READ. They then hold until the next ALU command.
          addr_write_reg <= bus.cmd_dst;
          addr0_reg      <= bus.cmd_src0;
          addr1_reg      <= bus.cmd_src1;
          select_reg     <= bus.cmd_op;
          error_reg      <= 1'b0;
        end else begin
          result_reg <= 8'd0;
          zero_reg   <= 1'b0;
          carry_reg  <= 1'b0;
          error_reg  <= 1'b1;
        end
      end
      // The operands were read in READ/EXEC, before the write-back in WRITE.
      // So dst may alias a source register.
      if (state_reg == EXEC) begin
        data_reg   <= bus.dp_result;
        result_reg <= bus.dp_result;
        zero_reg   <= bus.dp_zero_flag;
        carry_reg  <= bus.dp_carry_flag;
      end
    end
  end

  assign bus.dp_data       = data_reg;
  assign bus.dp_addr_write = addr_write_reg;
  assign bus.dp_addr0      = addr0_reg;
  assign bus.dp_addr1      = addr1_reg;
  assign bus.dp_select     = select_reg;
  assign bus.rsp_result    = result_reg;
  assign bus.rsp_zero      = zero_reg;
  assign bus.rsp_carry     = carry_reg;
  assign bus.rsp_error     = error_reg;

endmodule

// File: tb/tb_alu_ram_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_ram_sequencer
// Purpose : self-checking bench for alu_ram_sequencer.
//           - A behavioural register file and ALU model act as the datapath.
//           - Expected responses and expected register writes are pushed to
//             queues when a command is driven.
//           - Negedge monitors pop those queues and compare them against what
//             the sequencer produces.
// Ports   : none (top-level bench).
// ---------------------------------------------------------------------------
module tb_alu_ram_sequencer;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  alu_ram_sequencer_if bus();

  alu_ram_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [7:0] result;
    logic       zero;
    logic       carry;
    logic       error;
  } rsp_t;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  int checks      = 0;
  int passes      = 0;
  int write_count = 0;
  int cycle       = 0;
  int last_accept = 0;

  logic [7:0] dp_rf  [16];
  logic [7:0] ref_rf [16];
  logic [8:0] alu_out;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ALU behaviour: {carry, result}. For subtraction the carry is the borrow.
  function automatic logic [8:0] alu_fn(input logic [2:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {(a < b), 8'(a - b)};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      default: return 9'd0;
    endcase
  endfunction

  // Datapath model: the register file reads combinationally and writes on
  // the strobe.
  assign alu_out           = alu_fn(bus.dp_select, dp_rf[bus.dp_addr0],
                                    dp_rf[bus.dp_addr1]);
  assign bus.dp_result     = alu_out[7:0];
  assign bus.dp_carry_flag = alu_out[8];
  assign bus.dp_zero_flag  = (alu_out[7:0] == 8'd0);

  always @(posedge clock) begin
    cycle <= cycle + 1;
    if (bus.dp_write_enable) dp_rf[bus.dp_addr_write] <= bus.dp_data;
  end

  // Monitors: write strobes and response handshakes.
  always @(negedge clock) begin
    if (reset_n && bus.dp_write_enable) begin
      wr_t w;
      write_count++;
      check_val("write_expected", (wr_q.size() != 0), 1);
      if (wr_q.size() != 0) begin
        w = wr_q.pop_front();
        $display("write r%0d <= %0d", bus.dp_addr_write, bus.dp_data);
        check_val("wr_addr", bus.dp_addr_write, w.addr);
        check_val("wr_data", bus.dp_data, w.data);
      end
    end
    if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
      rsp_t r;
      check_val("rsp_expected", (rsp_q.size() != 0), 1);
      if (rsp_q.size() != 0) begin
        r = rsp_q.pop_front();
        $display("rsp result=%0d zero=%0b carry=%0b error=%0b",
                 bus.rsp_result, bus.rsp_zero, bus.rsp_carry, bus.rsp_error);
        check_val("rsp_result", bus.rsp_result, r.result);
        check_val("rsp_zero", bus.rsp_zero, r.zero);
        check_val("rsp_carry", bus.rsp_carry, r.carry);
        check_val("rsp_error", bus.rsp_error, r.error);
      end
    end
  end

  // Bit order of the vector:
  // {we, rsp_valid, rsp_error, busy, data, addr_w, addr0, addr1, select,
  //  result, zero, carry, cmd_ready}
  task automatic check_reset_outputs(input string tag);
    check_val(tag, {bus.dp_write_enable, bus.rsp_valid, bus.rsp_error, bus.busy,
                    bus.dp_data, bus.dp_addr_write, bus.dp_addr0, bus.dp_addr1,
                    bus.dp_select, bus.rsp_result, bus.rsp_zero, bus.rsp_carry,
                    bus.cmd_ready}, 64'd1);
  endtask

  // Drives one command. It is called at posedge+#1 with the DUT in IDLE.
  // - If rsp_ready is high, it returns at posedge+#1 back in IDLE.
  // - Otherwise it returns in RESP.
  // exp_gap is the expected accept-to-accept distance (0 = not checked).
  task automatic run_cmd(input logic load, input logic [2:0] op,
                         input logic [3:0] s0, input logic [3:0] s1,
                         input logic [3:0] d, input logic [7:0] imm,
                         input int exp_gap);
    rsp_t r;
    wr_t  w;
    logic [8:0] a;
    int exp_lat;
    int exp_wr;
    int lat;
    int wc0;
    if (load) begin
      r = '{result: imm, zero: (imm == 8'd0), carry: 1'b0, error: 1'b0};
      w = '{addr: d, data: imm};
      wr_q.push_back(w);
      ref_rf[d] = imm;
      exp_lat = 2;
      exp_wr  = 1;
    end else if (op <= 3'd4) begin
      a = alu_fn(op, ref_rf[s0], ref_rf[s1]);
      r = '{result: a[7:0], zero: (a[7:0] == 8'd0), carry: a[8], error: 1'b0};
      w = '{addr: d, data: a[7:0]};
      wr_q.push_back(w);
      ref_rf[d] = a[7:0];
      exp_lat = 4;
      exp_wr  = 1;
    end else begin
      r = '{result: 8'd0, zero: 1'b0, carry: 1'b0, error: 1'b1};
      exp_lat = 1;
      exp_wr  = 0;
    end
    rsp_q.push_back(r);
    $display("cmd load=%0b op=%0d src0=%0d src1=%0d dst=%0d imm=%0d",
             load, op, s0, s1, d, imm);
    check_val("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_load  = load;
    bus.cmd_op    = op;
    bus.cmd_src0  = s0;
    bus.cmd_src1  = s1;
    bus.cmd_dst   = d;
    bus.cmd_imm   = imm;
    bus.cmd_valid = 1'b1;
    wc0 = write_count;
    @(posedge clock); #1;
    if (exp_gap > 0) check_val("accept_gap", cycle - last_accept, exp_gap);
    last_accept   = cycle;
    // Scramble the fields so that any use after the accept edge shows up.
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'($urandom);
    bus.cmd_src0  = 4'($urandom);
    bus.cmd_src1  = 4'($urandom);
    bus.cmd_dst   = 4'($urandom);
    bus.cmd_imm   = 8'($urandom);
    bus.cmd_load  = 1'($urandom);
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      if (!load && op <= 3'd4 && lat <= 2)
        check_val("read_drives", {bus.dp_addr0, bus.dp_addr1, bus.dp_select},
                  {s0, s1, op});
      @(posedge clock); #1;
      lat++;
    end
    check_val("latency", lat, exp_lat);
    check_val("write_count", write_count - wc0, exp_wr);
    if (bus.rsp_ready) begin
      @(posedge clock); #1;
      check_val("idle_after_rsp", bus.busy, 0);
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_src0  = 4'd0;
    bus.cmd_src1  = 4'd0;
    bus.cmd_dst   = 4'd0;
    bus.cmd_imm   = 8'd0;
    for (int i = 0; i < 16; i++) ref_rf[i] = 8'd0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset_state");
    reset_n = 1'b1;

    // Loads, back to back.
    run_cmd(1'b1, 3'd0, 4'd0, 4'd0, 4'd1, 8'd100, 0);
    run_cmd(1'b1, 3'd0, 4'd0, 4'd0, 4'd2, 8'd50,  3);
    run_cmd(1'b1, 3'd0, 4'd0, 4'd0, 4'd3, 8'd150, 3);
    run_cmd(1'b1, 3'd0, 4'd0, 4'd0, 4'd4, 8'd250, 3);
    // ALU operations, including dst aliasing a source register.
    run_cmd(1'b0, 3'd0, 4'd4, 4'd2, 4'd5, 8'd0, 3);   // 250+50 = 44, carry 1
    run_cmd(1'b0, 3'd1, 4'd2, 4'd1, 4'd6, 8'd0, 5);   // 50-100 -> borrow
    run_cmd(1'b0, 3'd2, 4'd3, 4'd4, 4'd3, 8'd0, 5);   // dst == src0
    run_cmd(1'b0, 3'd4, 4'd1, 4'd1, 4'd1, 8'd0, 5);   // xor self -> zero
    // Illegal ops write nothing and respond one edge after accept.
    run_cmd(1'b0, 3'd6, 4'd1, 4'd2, 4'd7, 8'd0, 5);
    run_cmd(1'b0, 3'd5, 4'd1, 4'd2, 4'd7, 8'd0, 2);
    run_cmd(1'b0, 3'd7, 4'd1, 4'd2, 4'd7, 8'd0, 2);
    // A load ignores the op code. A zero immediate sets the zero flag.
    run_cmd(1'b1, 3'd7, 4'd0, 4'd0, 4'd8, 8'd0, 2);
    run_cmd(1'b0, 3'd3, 4'd8, 4'd5, 4'd9, 8'd0, 3);

    // Backpressure: the response must hold and a new command must be ignored.
    bus.rsp_ready = 1'b0;
    run_cmd(1'b0, 3'd0, 4'd6, 4'd5, 4'd10, 8'd0, 0);
    begin
      rsp_t held;
      int wc0;
      held = rsp_q[0];
      wc0  = write_count;
      for (int i = 0; i < 5; i++) begin
        check_val("bp_valid", bus.rsp_valid, 1);
        check_val("bp_ready_low", bus.cmd_ready, 0);
        check_val("bp_stable", {bus.rsp_result, bus.rsp_zero, bus.rsp_carry,
                                bus.rsp_error}, held);
        if (i == 2) begin
          bus.cmd_valid = 1'b1;
          bus.cmd_load  = 1'b1;
          bus.cmd_dst   = 4'd7;
          bus.cmd_imm   = 8'h5A;
        end else begin
          bus.cmd_valid = 1'b0;
        end
        @(posedge clock); #1;
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clock); #1;
      check_val("bp_idle", bus.busy, 0);
      check_val("bp_no_write", write_count - wc0, 0);
    end

    // Reset in the middle of WRITE aborts the command.
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_src0  = 4'd1;
    bus.cmd_src1  = 4'd2;
    bus.cmd_dst   = 4'd15;
    bus.cmd_valid = 1'b1;
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check_val("we_in_write", bus.dp_write_enable, 1);
    reset_n = 1'b0;
    @(posedge clock); #1;
    check_val("we_after_reset", bus.dp_write_enable, 0);
    check_reset_outputs("reset_mid_write");
    @(posedge clock); #1;
    check_val("we_in_reset", bus.dp_write_enable, 0);
    reset_n = 1'b1;
    $display("reset pulse during WRITE done");

    // Normal operation resumes after the reset.
    run_cmd(1'b1, 3'd0, 4'd0, 4'd0, 4'd11, 8'd77, 0);
    run_cmd(1'b0, 3'd0, 4'd11, 4'd1, 4'd12, 8'd0, 3);

    repeat (2) @(posedge clock);
    check_val("rsp_q_empty", rsp_q.size(), 0);
    check_val("wr_q_empty", wr_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
